// File: rtl/data_memory_stack.sv
// data_memory_stack: word-addressed data memory with a hardware stack that
// grows downward from STACK_BASE. After reset an init sweep zeroes the array
// (busy=1), then absolute load/store and push/pop requests are served.
// Optional feature macro: STACK_GUARD_EN -- when defined, load/store to an
// address inside the stack range is rejected with err_code=11.
//
// Request protocol: store/load/push/pop are single-cycle strobes sampled on
// each rising edge. A request is accepted only when exactly one strobe is high
// and the block is idle. Writes land at the sampling edge. Read data appears on
// data_out together with a one-cycle rvalid pulse right after that edge. A
// rejected request produces a one-cycle err pulse with err_code and changes
// nothing else.
module data_memory_stack #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 9,
  parameter int STACK_BASE  = 2**ADDR_W - 1,
  parameter int STACK_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] address,
  input  logic              store,
  input  logic              load,
  input  logic              push,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              rvalid,
  output logic [ADDR_W-1:0] sp_out,
  output logic              full,
  output logic              empty,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W-1:0] SP_BASE  = ADDR_W'(STACK_BASE);
  localparam logic [ADDR_W-1:0] SP_FULL  = ADDR_W'(STACK_BASE - STACK_DEPTH);
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

  typedef enum logic {
    S_INIT = 1'b0,
    S_IDLE = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0] init_ptr;
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W-1:0] sp_next;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              err_next;
  logic [1:0]        code_next;

  logic [2:0]        req_count;
  logic              any_req;
  logic              multi_req;
  logic              addr_blocked;

  assign req_count = {2'b00, store} + {2'b00, load} + {2'b00, push} + {2'b00, pop};
  assign any_req   = (req_count != 3'd0);
  assign multi_req = (req_count > 3'd1);

`ifdef STACK_GUARD_EN
  // Absolute accesses may not touch live stack words [SP_FULL+1, SP_BASE].
  assign addr_blocked = (address > SP_FULL) && (address <= SP_BASE);
`else
  assign addr_blocked = 1'b0;
`endif

  assign busy     = (state == S_INIT);
  assign sp_out   = sp;
  assign full     = (sp == SP_FULL);
  assign empty    = (sp == SP_BASE);

  // State register: reset always restarts the init sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, request decode, memory write and read control.
  always_comb begin
    state_next = state;
    sp_next    = sp;
    mem_we     = 1'b0;
    mem_waddr  = init_ptr;
    mem_wdata  = '0;
    rd_en      = 1'b0;
    rd_addr    = address;
    err_next   = 1'b0;
    code_next  = ERR_NONE;

    case (state)
      S_INIT: begin
        // Zero one word per cycle; leave after the last address is written.
        mem_we    = 1'b1;
        mem_waddr = init_ptr;
        mem_wdata = '0;
        if (init_ptr == PTR_LAST) begin
          state_next = S_IDLE;
        end
        if (any_req) begin
          err_next  = 1'b1;
          code_next = ERR_ILLEGAL;
        end
      end

      S_IDLE: begin
        if (multi_req) begin
          err_next  = 1'b1;
          code_next = ERR_ILLEGAL;
        end else if (store) begin
          if (addr_blocked) begin
            err_next  = 1'b1;
            code_next = ERR_ILLEGAL;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = address;
            mem_wdata = data_in;
          end
        end else if (load) begin
          if (addr_blocked) begin
            err_next  = 1'b1;
            code_next = ERR_ILLEGAL;
          end else begin
            rd_en   = 1'b1;
            rd_addr = address;
          end
        end else if (push) begin
          if (sp == SP_FULL) begin
            err_next  = 1'b1;
            code_next = ERR_OVERFLOW;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = sp;
            mem_wdata = data_in;
            sp_next   = sp - ONE;
          end
        end else if (pop) begin
          if (sp == SP_BASE) begin
            err_next  = 1'b1;
            code_next = ERR_UNDERFLOW;
          end else begin
            sp_next = sp + ONE;
            rd_en   = 1'b1;
            rd_addr = sp + ONE;
          end
        end
      end

      default: begin
        state_next = S_INIT;
      end
    endcase
  end

  // Memory array write port; contents are not touched by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Datapath registers: init pointer, stack pointer, read data and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_ptr <= '0;
      sp       <= SP_BASE;
      data_out <= '0;
      rvalid   <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      if (state == S_INIT) begin
        init_ptr <= init_ptr + ONE;
      end
      sp       <= sp_next;
      rvalid   <= rd_en;
      if (rd_en) begin
        data_out <= mem[rd_addr];
      end
      err      <= err_next;
      err_code <= code_next;
    end
  end

endmodule

// File: tb/tb_data_memory_stack.sv
// Directed self-checking bench for data_memory_stack (default parameters).
module tb_data_memory_stack;

  logic        clk;
  logic        reset;
  logic [15:0] data_in;
  logic [8:0]  address;
  logic        store;
  logic        load;
  logic        push;
  logic        pop;
  logic [15:0] data_out;
  logic        rvalid;
  logic [8:0]  sp_out;
  logic        full;
  logic        empty;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;

  int pass_cnt;
  int total_cnt;

  data_memory_stack dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .address  (address),
    .store    (store),
    .load     (load),
    .push     (push),
    .pop      (pop),
    .data_out (data_out),
    .rvalid   (rvalid),
    .sp_out   (sp_out),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .err      (err),
    .err_code (err_code)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one request for one clock edge, sample #1 after the edge.
  task automatic issue(input logic s, input logic l, input logic pu, input logic po,
                       input logic [8:0] a, input logic [15:0] d);
    @(negedge clk);
    store   = s;
    load    = l;
    push    = pu;
    pop     = po;
    address = a;
    data_in = d;
    @(posedge clk);
    #1;
    store = 1'b0;
    load  = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Driver: pulse reset and return with reset released (sweep starting).
  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Driver: bounded wait for the init sweep to finish; returns cycles seen busy.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 1000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    int cycles;
    @(negedge clk);
    reset = 1'b1;
    #2;
    total_cnt++;
    if (busy !== 1'b1 || sp_out !== 9'd511 || rvalid !== 1'b0 || err !== 1'b0 ||
        err_code !== 2'b00 || data_out !== 16'h0000 || empty !== 1'b1 || full !== 1'b0)
      $display("FAIL reset_state busy=%b sp=%0d rvalid=%b err=%b code=%b dout=%h empty=%b full=%b required 1 511 0 0 00 0000 1 0",
               busy, sp_out, rvalid, err, err_code, data_out, empty, full);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_idle(cycles);
    total_cnt++;
    if (cycles !== 512) $display("FAIL busy_length got %0d required 512", cycles);
    else pass_cnt++;
    issue(0, 1, 0, 0, 9'd5, 16'h0);
    total_cnt++;
    if (rvalid !== 1'b1 || data_out !== 16'h0000 || err !== 1'b0)
      $display("FAIL load_after_init rvalid=%b dout=%h err=%b required 1 0000 0", rvalid, data_out, err);
    else pass_cnt++;
    idle_cycle();
    total_cnt++;
    if (rvalid !== 1'b0) $display("FAIL rvalid_pulse got %b required 0", rvalid);
    else pass_cnt++;
  endtask

  task automatic test_store_load();
    issue(1, 0, 0, 0, 9'd1, 16'hAAAA);
    total_cnt++;
    if (rvalid !== 1'b0 || err !== 1'b0) $display("FAIL store_status rvalid=%b err=%b required 0 0", rvalid, err);
    else pass_cnt++;
    idle_cycle();
    issue(0, 1, 0, 0, 9'd1, 16'h0);
    total_cnt++;
    if (data_out !== 16'hAAAA || rvalid !== 1'b1)
      $display("FAIL load_1 dout=%h rvalid=%b required aaaa 1", data_out, rvalid);
    else pass_cnt++;
    issue(1, 0, 0, 0, 9'd2, 16'h5555);
    issue(0, 1, 0, 0, 9'd2, 16'h0);
    total_cnt++;
    if (data_out !== 16'h5555 || rvalid !== 1'b1)
      $display("FAIL store_then_load dout=%h rvalid=%b required 5555 1", data_out, rvalid);
    else pass_cnt++;
    issue(0, 1, 0, 0, 9'd1, 16'h0);
    total_cnt++;
    if (data_out !== 16'hAAAA) $display("FAIL load_1_again dout=%h required aaaa", data_out);
    else pass_cnt++;
  endtask

  task automatic test_push_pop();
    issue(0, 0, 1, 0, 9'd0, 16'hF0F0);
    total_cnt++;
    if (sp_out !== 9'd510 || empty !== 1'b0 || err !== 1'b0)
      $display("FAIL push_1 sp=%0d empty=%b err=%b required 510 0 0", sp_out, empty, err);
    else pass_cnt++;
    issue(0, 0, 1, 0, 9'd0, 16'h1234);
    total_cnt++;
    if (sp_out !== 9'd509) $display("FAIL push_2 sp=%0d required 509", sp_out);
    else pass_cnt++;
    issue(0, 0, 0, 1, 9'd0, 16'h0);
    total_cnt++;
    if (data_out !== 16'h1234 || rvalid !== 1'b1 || sp_out !== 9'd510)
      $display("FAIL pop_1 dout=%h rvalid=%b sp=%0d required 1234 1 510", data_out, rvalid, sp_out);
    else pass_cnt++;
    issue(0, 0, 0, 1, 9'd0, 16'h0);
    total_cnt++;
    if (data_out !== 16'hF0F0 || sp_out !== 9'd511 || empty !== 1'b1)
      $display("FAIL pop_2 dout=%h sp=%0d empty=%b required f0f0 511 1", data_out, sp_out, empty);
    else pass_cnt++;
    issue(0, 0, 1, 0, 9'd0, 16'hC3C3);
    issue(0, 0, 0, 1, 9'd0, 16'h0);
    total_cnt++;
    if (data_out !== 16'hC3C3 || rvalid !== 1'b1 || sp_out !== 9'd511)
      $display("FAIL back_to_back dout=%h rvalid=%b sp=%0d required c3c3 1 511", data_out, rvalid, sp_out);
    else pass_cnt++;
  endtask

  task automatic test_overflow_underflow();
    for (int i = 0; i < 64; i++) issue(0, 0, 1, 0, 9'd0, 16'h1000 + 16'(i));
    total_cnt++;
    if (full !== 1'b1 || sp_out !== 9'd447)
      $display("FAIL full_after_64 full=%b sp=%0d required 1 447", full, sp_out);
    else pass_cnt++;
    issue(0, 0, 1, 0, 9'd0, 16'hDEAD);
    total_cnt++;
    if (err !== 1'b1 || err_code !== 2'b01 || sp_out !== 9'd447)
      $display("FAIL overflow err=%b code=%b sp=%0d required 1 01 447", err, err_code, sp_out);
    else pass_cnt++;
    idle_cycle();
    total_cnt++;
    if (err !== 1'b0 || err_code !== 2'b00)
      $display("FAIL err_clear err=%b code=%b required 0 00", err, err_code);
    else pass_cnt++;
    issue(0, 0, 0, 1, 9'd0, 16'h0);
    total_cnt++;
    if (data_out !== 16'h103F || sp_out !== 9'd448)
      $display("FAIL pop_top dout=%h sp=%0d required 103f 448", data_out, sp_out);
    else pass_cnt++;
    for (int i = 0; i < 63; i++) issue(0, 0, 0, 1, 9'd0, 16'h0);
    total_cnt++;
    if (data_out !== 16'h1000 || empty !== 1'b1 || sp_out !== 9'd511)
      $display("FAIL pop_all dout=%h empty=%b sp=%0d required 1000 1 511", data_out, empty, sp_out);
    else pass_cnt++;
    issue(0, 0, 0, 1, 9'd0, 16'h0);
    total_cnt++;
    if (err !== 1'b1 || err_code !== 2'b10 || rvalid !== 1'b0 || sp_out !== 9'd511 || data_out !== 16'h1000)
      $display("FAIL underflow err=%b code=%b rvalid=%b sp=%0d dout=%h required 1 10 0 511 1000",
               err, err_code, rvalid, sp_out, data_out);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    int cycles;
    issue(1, 0, 1, 0, 9'd3, 16'hBEEF);
    total_cnt++;
    if (err !== 1'b1 || err_code !== 2'b11 || sp_out !== 9'd511 || rvalid !== 1'b0)
      $display("FAIL store_push err=%b code=%b sp=%0d rvalid=%b required 1 11 511 0", err, err_code, sp_out, rvalid);
    else pass_cnt++;
    issue(0, 1, 0, 0, 9'd3, 16'h0);
    total_cnt++;
    if (data_out !== 16'h0000 || rvalid !== 1'b1)
      $display("FAIL no_write_on_illegal dout=%h rvalid=%b required 0000 1", data_out, rvalid);
    else pass_cnt++;
    issue(0, 1, 0, 1, 9'd1, 16'h0);
    total_cnt++;
    if (err_code !== 2'b11 || rvalid !== 1'b0 || sp_out !== 9'd511 || data_out !== 16'h0000)
      $display("FAIL load_pop code=%b rvalid=%b sp=%0d dout=%h required 11 0 511 0000", err_code, rvalid, sp_out, data_out);
    else pass_cnt++;
    pulse_reset();
    repeat (4) idle_cycle();
    issue(1, 0, 0, 0, 9'd4, 16'h1234);
    total_cnt++;
    if (err !== 1'b1 || err_code !== 2'b11 || busy !== 1'b1)
      $display("FAIL req_while_busy err=%b code=%b busy=%b required 1 11 1", err, err_code, busy);
    else pass_cnt++;
    wait_idle(cycles);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reinit_timeout busy=%b required 0", busy);
    else pass_cnt++;
    issue(0, 1, 0, 0, 9'd1, 16'h0);
    total_cnt++;
    if (data_out !== 16'h0000 || rvalid !== 1'b1)
      $display("FAIL rezeroed dout=%h rvalid=%b required 0000 1", data_out, rvalid);
    else pass_cnt++;
  endtask

  task automatic test_stack_addr();
    for (int i = 0; i < 12; i++) issue(0, 0, 1, 0, 9'd0, 16'h2000 + 16'(i));
    total_cnt++;
    if (sp_out !== 9'd499) $display("FAIL sp_499 sp=%0d required 499", sp_out);
    else pass_cnt++;
    issue(1, 0, 0, 0, 9'd500, 16'h7777);
`ifdef STACK_GUARD_EN
    total_cnt++;
    if (err !== 1'b1 || err_code !== 2'b11)
      $display("FAIL guard_store err=%b code=%b required 1 11", err, err_code);
    else pass_cnt++;
    issue(0, 1, 0, 0, 9'd500, 16'h0);
    total_cnt++;
    if (err_code !== 2'b11 || rvalid !== 1'b0)
      $display("FAIL guard_load code=%b rvalid=%b required 11 0", err_code, rvalid);
    else pass_cnt++;
    issue(0, 0, 0, 1, 9'd0, 16'h0);
    total_cnt++;
    if (data_out !== 16'h200B || sp_out !== 9'd500)
      $display("FAIL guard_pop dout=%h sp=%0d required 200b 500", data_out, sp_out);
    else pass_cnt++;
`else
    total_cnt++;
    if (err !== 1'b0) $display("FAIL stack_store err=%b required 0", err);
    else pass_cnt++;
    issue(0, 0, 0, 1, 9'd0, 16'h0);
    total_cnt++;
    if (data_out !== 16'h7777 || sp_out !== 9'd500 || rvalid !== 1'b1)
      $display("FAIL stack_pop dout=%h sp=%0d rvalid=%b required 7777 500 1", data_out, sp_out, rvalid);
    else pass_cnt++;
`endif
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b0;
    store     = 1'b0;
    load      = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    address   = '0;
    data_in   = '0;
    test_reset();
    test_store_load();
    test_push_pop();
    test_overflow_underflow();
    test_illegal();
    test_stack_addr();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
